// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: hazard FSM states, forwarding mux encodings, NOP.
// No logic; constants and types only.
// No flow control.
package pipeline_pkg;

    // Hazard controller states
    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_ERROR    = 2'd2
    } hazard_state_e;

    // Forwarding mux select encodings used by the EX-stage forwarding unit
    localparam logic [1:0] FWD_REGFILE = 2'b00;
    localparam logic [1:0] FWD_MEM     = 2'b01;
    localparam logic [1:0] FWD_WB      = 2'b10;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/hazard_perf_cnt.sv
// Three free-running performance counters advanced by single-cycle strobes.
// Latency: count visible the cycle after the strobe.
// No backpressure; counters wrap modulo 2^CNT_W.
module hazard_perf_cnt #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc_load,
    input  logic             inc_flush,
    input  logic             inc_wait,
    input  logic [CNT_W-1:0] zero_unused_guard,
    output logic [CNT_W-1:0] load_stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [CNT_W-1:0] mem_wait_cnt
);

    // Count each strobe; synchronous clear on reset
    always_ff @(posedge clk) begin
        if (reset) begin
            load_stall_cnt <= zero_unused_guard;
            flush_cnt      <= zero_unused_guard;
            mem_wait_cnt   <= zero_unused_guard;
        end else begin
            if (inc_load)  load_stall_cnt <= load_stall_cnt + 1'b1;
            if (inc_flush) flush_cnt      <= flush_cnt + 1'b1;
            if (inc_wait)  mem_wait_cnt   <= mem_wait_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard controller: load-use bubbles, branch flushes, dmem-wait freeze + timeout watchdog.
// Latency: control outputs are combinational from state and same-cycle inputs.
// Backpressure: dmem wait freezes all stage registers; HAZARD_PERF_EN enables perf counters.
module hazard_unit
    import pipeline_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       rs1_id,
    input  logic [4:0]       rs2_id,
    input  logic             use_rs1_id,
    input  logic             use_rs2_id,
    input  logic [4:0]       rd_ex,
    input  logic             MemRead_ex,
    input  logic             branch_taken_ex,
    input  logic             dmem_req_mem,
    input  logic             dmem_ready,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             idex_write,
    output logic             exmem_write,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             memwb_bubble,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] load_stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [CNT_W-1:0] mem_wait_cnt
);

    // Wide enough to hold MEM_TIMEOUT itself
    localparam int WAIT_W = $clog2(MEM_TIMEOUT) + 1;

    hazard_state_e     state, state_nxt;
    logic [WAIT_W-1:0] wait_cnt, wait_nxt;
    logic              mem_stall, load_use, active;

    assign mem_stall = dmem_req_mem & ~dmem_ready;
    assign load_use  = MemRead_ex & (rd_ex != 5'd0) &
                       ((use_rs1_id & (rs1_id == rd_ex)) | (use_rs2_id & (rs2_id == rd_ex)));
    assign active    = (state != ST_ERROR);

    // Stage enables/flushes by priority: reset > error > mem stall > branch > load-use
    always_comb begin
        pc_write     = 1'b1;
        ifid_write   = 1'b1;
        idex_write   = 1'b1;
        exmem_write  = 1'b1;
        ifid_flush   = 1'b0;
        idex_flush   = 1'b0;
        memwb_bubble = 1'b0;
        if (reset) begin
            {pc_write, ifid_write, idex_write, exmem_write} = 4'b0000;
            {ifid_flush, idex_flush, memwb_bubble}          = 3'b111;
        end else if (!active || mem_stall) begin
            {pc_write, ifid_write, idex_write, exmem_write} = 4'b0000;
            memwb_bubble                                    = 1'b1;
        end else if (branch_taken_ex) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else if (load_use) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            idex_flush = 1'b1;
        end
    end

    assign mem_timeout = ~reset & (state == ST_ERROR);

    // Next state and consecutive-stall count; the first stall in RUN counts as stall #1
    always_comb begin
        state_nxt = state;
        wait_nxt  = wait_cnt;
        case (state)
            ST_RUN: begin
                if (mem_stall) begin
                    state_nxt = ST_MEM_WAIT;
                    wait_nxt  = wait_cnt + 1'b1;
                end else begin
                    wait_nxt  = '0;
                end
            end
            ST_MEM_WAIT: begin
                if (!mem_stall) begin
                    state_nxt = ST_RUN;
                    wait_nxt  = '0;
                end else begin
                    wait_nxt  = wait_cnt + 1'b1;
                    if (wait_cnt == WAIT_W'(MEM_TIMEOUT - 1)) state_nxt = ST_ERROR;
                end
            end
            ST_ERROR: begin
                state_nxt = ST_ERROR;
            end
            default: begin
                state_nxt = ST_RUN;
                wait_nxt  = '0;
            end
        endcase
    end

    // FSM state and wait counter registers; ERROR is left only through reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_RUN;
            wait_cnt <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_nxt;
        end
    end

`ifdef HAZARD_PERF_EN
    logic inc_load, inc_flush, inc_wait;

    assign inc_wait  = ~reset & active & mem_stall;
    assign inc_flush = ~reset & active & ~mem_stall & branch_taken_ex;
    assign inc_load  = ~reset & active & ~mem_stall & ~branch_taken_ex & load_use;

    hazard_perf_cnt #(.CNT_W(CNT_W)) u_perf (
        .clk               (clk),
        .reset             (reset),
        .inc_load          (inc_load),
        .inc_flush         (inc_flush),
        .inc_wait          (inc_wait),
        .zero_unused_guard ({CNT_W{1'b0}}),
        .load_stall_cnt    (load_stall_cnt),
        .flush_cnt         (flush_cnt),
        .mem_wait_cnt      (mem_wait_cnt)
    );
`else
    assign load_stall_cnt = '0;
    assign flush_cnt      = '0;
    assign mem_wait_cnt   = '0;
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Randomized + directed bench for hazard_unit with a queue-based scoreboard.
// Expected responses come from a run-length / flag reference model.
// Monitor compares on the falling edge, one entry per cycle.
module tb_hazard_unit;

    localparam int MEM_TIMEOUT = 16;
    localparam int CNT_W       = 32;

    logic             clk = 1'b0;
    logic             reset;
    logic [4:0]       rs1_id, rs2_id, rd_ex;
    logic             use_rs1_id, use_rs2_id, MemRead_ex, branch_taken_ex;
    logic             dmem_req_mem, dmem_ready;
    logic             pc_write, ifid_write, idex_write, exmem_write;
    logic             ifid_flush, idex_flush, memwb_bubble, mem_timeout;
    logic [CNT_W-1:0] load_stall_cnt, flush_cnt, mem_wait_cnt;

    always #5 clk = ~clk;

    hazard_unit #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk             (clk),
        .reset           (reset),
        .rs1_id          (rs1_id),
        .rs2_id          (rs2_id),
        .use_rs1_id      (use_rs1_id),
        .use_rs2_id      (use_rs2_id),
        .rd_ex           (rd_ex),
        .MemRead_ex      (MemRead_ex),
        .branch_taken_ex (branch_taken_ex),
        .dmem_req_mem    (dmem_req_mem),
        .dmem_ready      (dmem_ready),
        .pc_write        (pc_write),
        .ifid_write      (ifid_write),
        .idex_write      (idex_write),
        .exmem_write     (exmem_write),
        .ifid_flush      (ifid_flush),
        .idex_flush      (idex_flush),
        .memwb_bubble    (memwb_bubble),
        .mem_timeout     (mem_timeout),
        .load_stall_cnt  (load_stall_cnt),
        .flush_cnt       (flush_cnt),
        .mem_wait_cnt    (mem_wait_cnt)
    );

    typedef struct packed {
        logic       rst;
        logic [4:0] rs1, rs2;
        logic       u1, u2;
        logic [4:0] rd;
        logic       mr, br, req, rdy;
    } stim_t;

    typedef struct packed {
        logic [6:0]  ctrl;    // pc,ifid,idex,exmem writes, ifid_flush, idex_flush, memwb_bubble
        logic        chk_to;
        logic        to;
        logic        chk_cnt;
        logic [31:0] ld, fl, mw;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    // Reference model state: consecutive stall run, sticky error, event tallies
    int          run_len = 0;
    bit          err     = 0;
    bit          known   = 0;
    int unsigned m_ld = 0, m_fl = 0, m_mw = 0;

    task automatic drive(input stim_t s);
        exp_t e;
        bit   stall, lu;
        @(posedge clk);
        #1;
        reset = s.rst; rs1_id = s.rs1; rs2_id = s.rs2; use_rs1_id = s.u1; use_rs2_id = s.u2;
        rd_ex = s.rd; MemRead_ex = s.mr; branch_taken_ex = s.br;
        dmem_req_mem = s.req; dmem_ready = s.rdy;

        stall = s.req && !s.rdy;
        lu    = s.mr && (s.rd != 0) && ((s.u1 && s.rs1 == s.rd) || (s.u2 && s.rs2 == s.rd));

        if (s.rst)              e.ctrl = 7'b0000_111;
        else if (err || stall)  e.ctrl = 7'b0000_001;
        else if (s.br)          e.ctrl = 7'b1111_110;
        else if (lu)            e.ctrl = 7'b0011_010;
        else                    e.ctrl = 7'b1111_000;
        e.chk_to  = !s.rst;
        e.to      = err;
        e.chk_cnt = known;
`ifdef HAZARD_PERF_EN
        e.ld = m_ld; e.fl = m_fl; e.mw = m_mw;
`else
        e.ld = 0; e.fl = 0; e.mw = 0;
`endif
        exp_q.push_back(e);

        // Advance model to the state after this clock edge
        if (s.rst) begin
            run_len = 0; err = 0; known = 1; m_ld = 0; m_fl = 0; m_mw = 0;
        end else if (!err) begin
            if (stall) begin
                run_len++;
                m_mw++;
                if (run_len >= MEM_TIMEOUT) err = 1;
            end else begin
                run_len = 0;
                if (s.br)    m_fl++;
                else if (lu) m_ld++;
            end
        end
    endtask

    task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: one expected response per cycle, compared mid-cycle
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check_val("ctrl", {25'd0, pc_write, ifid_write, idex_write, exmem_write,
                               ifid_flush, idex_flush, memwb_bubble}, {25'd0, e.ctrl});
            if (e.chk_to) check_val("mem_timeout", {31'd0, mem_timeout}, {31'd0, e.to});
            if (e.chk_cnt) begin
                check_val("load_stall_cnt", load_stall_cnt, e.ld);
                check_val("flush_cnt", flush_cnt, e.fl);
                check_val("mem_wait_cnt", mem_wait_cnt, e.mw);
            end
        end
    end

    function automatic stim_t idle();
        stim_t s;
        s = '0;
        s.rdy = 1'b1;
        return s;
    endfunction

    initial begin
        stim_t s;
        reset = 1'b1; rs1_id = '0; rs2_id = '0; use_rs1_id = 0; use_rs2_id = 0;
        rd_ex = '0; MemRead_ex = 0; branch_taken_ex = 0; dmem_req_mem = 0; dmem_ready = 1;

        s = idle(); s.rst = 1; drive(s); drive(s);

        // lw x5 then add using x5: one bubble, then normal
        s = idle(); s.mr = 1; s.rd = 5; s.rs1 = 5; s.u1 = 1; drive(s);
        s = idle(); drive(s);
        // rd_ex = x0 never stalls
        s = idle(); s.mr = 1; s.rd = 0; s.rs1 = 0; s.u1 = 1; drive(s);
        // branch wins over load-use
        s = idle(); s.mr = 1; s.rd = 7; s.rs2 = 7; s.u2 = 1; s.br = 1; drive(s);
        // three-cycle dmem wait, then release
        s = idle(); s.req = 1; s.rdy = 0;
        repeat (3) drive(s);
        s.rdy = 1; drive(s); drive(idle());

        // reset in mid-wait; afterwards a 15-stall run must not time out
        s = idle(); s.req = 1; s.rdy = 0;
        repeat (5) drive(s);
        s.rst = 1; drive(s);
        s.rst = 0;
        repeat (MEM_TIMEOUT - 1) drive(s);
        drive(idle());
        // full timeout: error sticks through later ready/branch cycles
        repeat (MEM_TIMEOUT + 2) drive(s);
        s = idle(); s.br = 1; drive(s); drive(s);
        s = idle(); s.rst = 1; drive(s);
        drive(idle());

        // randomized traffic, with a low-ready phase to reach the watchdog
        for (int i = 0; i < 1500; i++) begin
            s.rst = ($urandom_range(0, 99) < 2);
            s.rs1 = 5'($urandom_range(0, 3));
            s.rs2 = 5'($urandom_range(0, 3));
            s.rd  = 5'($urandom_range(0, 3));
            s.u1  = 1'($urandom);
            s.u2  = 1'($urandom);
            s.mr  = 1'($urandom);
            s.br  = ($urandom_range(0, 9) < 2);
            s.req = ($urandom_range(0, 9) < 4);
            s.rdy = (i > 1000) ? ($urandom_range(0, 19) < 1) : 1'($urandom);
            drive(s);
        end

        drive(idle());
        repeat (2) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain actual=%0d required=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hazard_unit.md
# hazard_unit

Pipeline hazard controller for the 5-stage RISC-V core, sitting in ID beside the EX-stage forwarding unit. Covers hazards that forwarding cannot resolve: load-use stalls (bubble into ID/EX), taken-branch flushes, and data-memory wait freezes with a timeout watchdog. Drives the write-enable and flush controls of PC, IF/ID, ID/EX, EX/MEM and MEM/WB.

## Interface
- MEM_TIMEOUT, 16: max consecutive dmem wait cycles before error (≥2)
- CNT_W, 32: perf-counter width
- clk  in  1  core clock; single clock domain
- reset  in  1  synchronous, active-high
- rs1_id, rs2_id  in  5 each  source regs of instruction in ID
- use_rs1_id, use_rs2_id  in  1 each  ID instruction actually reads rs1/rs2
- rd_ex  in  5  dest reg of instruction in EX
- MemRead_ex  in  1  EX instruction is a load
- branch_taken_ex  in  1  EX resolved a taken branch/jump
- dmem_req_mem  in  1  MEM stage has an active dmem access
- dmem_ready  in  1  dmem completes access this cycle
- pc_write, ifid_write, idex_write, exmem_write  out  1 each  register enables
- ifid_flush, idex_flush, memwb_bubble  out  1 each  insert NOP into that register
- mem_timeout  out  1  sticky error
- load_stall_cnt, flush_cnt, mem_wait_cnt  out  CNT_W each  perf counters

## Operation
- FSM states: RUN, MEM_WAIT, ERROR. Control outputs combinational from state and current inputs; state, wait counter, perf counters registered.
- mem_stall = dmem_req_mem & ~dmem_ready.
- load_use = MemRead_ex & (rd_ex≠0) & ((use_rs1_id & rs1_id==rd_ex) | (use_rs2_id & rs2_id==rd_ex)).
- Priority per cycle (RUN/MEM_WAIT): mem_stall > branch_taken_ex > load_use > normal.
  - mem_stall: all four enables 0, memwb_bubble=1, flushes 0.
  - branch: all enables 1, ifid_flush=1, idex_flush=1.
  - load_use: pc_write=0, ifid_write=0, idex_flush=1, other enables 1.
  - normal: all enables 1, flushes/bubble 0.
- Transitions: RUN→MEM_WAIT when mem_stall; MEM_WAIT→RUN when !mem_stall; MEM_WAIT→ERROR when mem_stall and wait_cnt==MEM_TIMEOUT-1. wait_cnt clears on entry to RUN, increments each MEM_WAIT stall cycle.
- ERROR: all enables 0, memwb_bubble=1, mem_timeout=1; exit only via reset.
- Branch/load-use hidden behind mem_stall are re-evaluated when the freeze lifts (inputs held by frozen registers).
- rd_ex==0 never stalls.

## Timing
- Control outputs zero-latency w.r.t. inputs in same cycle.
- Load-use: exactly one bubble; next cycle load is in MEM, hazard clears, forwarding takes over.
- mem_timeout rises cycle after the MEM_TIMEOUT-th consecutive stall cycle.
- Reset (incl. mid-stall): state→RUN, wait_cnt=0, mem_timeout=0, counters=0; while reset high, enables 0, ifid_flush=idex_flush=memwb_bubble=1.
- Counters wrap modulo 2^CNT_W.

## Configuration
- HAZARD_PERF_EN defined: load_stall_cnt +1 per load_use-selected cycle, flush_cnt +1 per branch-selected cycle, mem_wait_cnt +1 per mem_stall cycle (RUN/MEM_WAIT only).
- Undefined: counter ports remain, tied to 0; no counter flops.

## Structure
- Package pipeline_pkg: hazard FSM state enum, forwardA/B encodings (00 regfile, 01 MEM, 10 WB), NOP instruction constant.
- Sub-module hazard_perf_cnt: three CNT_W counters with increment strobes, instantiated only under HAZARD_PERF_EN.

## Test plan
- lw x5 in EX (rd_ex=5, MemRead_ex=1), ID add uses rs1=5 → one cycle pc_write=0, ifid_write=0, idex_flush=1; next cycle all 1; load_stall_cnt=1.
- MemRead_ex=1, rd_ex=0, rs1_id=0, use_rs1_id=1 → no stall.
- branch_taken_ex=1 with load_use true → ifid_flush=idex_flush=1, pc_write=1; flush_cnt=1, load_stall_cnt=0.
- dmem_req_mem=1, dmem_ready=0 for 3 cycles then 1 → enables 0 three cycles, MEM_WAIT, back to RUN; mem_wait_cnt=3.
- dmem_ready held 0 with MEM_TIMEOUT=16 → mem_timeout=1 after 16 stall cycles, stays 1; reset clears to RUN, all counters 0.
- Reset asserted mid-MEM_WAIT → next cycle state RUN, wait_cnt=0, flush outputs 1 during reset.
